// File: rtl/fc1_weight_framer_if.sv
// rtl/fc1_weight_framer_if.sv - weight block stream bundle between source, framer and fc1 datapath
interface fc1_weight_framer_if #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE-1:0][WIDTH-1:0] data_in;
  logic                       data_in_valid;
  logic                       data_in_ready;
  logic [SIZE-1:0][WIDTH-1:0] data_out;
  logic                       data_out_valid;
  logic                       data_out_ready;
  logic [IDX_W-1:0]           data_out_index;
  logic                       data_out_last;

  // Environment side: drives upstream beats and downstream ready
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, data_out_index, data_out_last
  );

  // Framer side
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, data_out_index, data_out_last
  );
endinterface

// File: rtl/fc1_weight_framer.sv
// rtl/fc1_weight_framer.sv - skid-buffered, index-tagged weight block framer counting fixed passes
module fc1_weight_framer #(
  parameter  int SIZE       = 32,
  parameter  int WIDTH      = 16,
  parameter  int DEPTH      = 8,
  parameter  int NUM_PASSES = 4,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PC_W       = $clog2(NUM_PASSES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  fc1_weight_framer_if.slave   bus,
  output logic [PC_W-1:0]      pass_count,
  output logic                 done
);

  localparam int TOTAL = NUM_PASSES * DEPTH;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] FINAL_C    = CNT_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {S_RUN, S_DONE} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_in_cnt;
  logic [CNT_W-1:0]           r_out_cnt;
  logic [PC_W-1:0]            r_pass_count;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_in_ready;
  logic                       r_done;

  logic                       r_main_valid;
  logic [SIZE-1:0][WIDTH-1:0] r_main_data;
  logic [IDX_W-1:0]           r_main_idx;
  logic                       r_skid_valid;
  logic [SIZE-1:0][WIDTH-1:0] r_skid_data;
  logic [IDX_W-1:0]           r_skid_idx;

  logic                       w_in_fire;
  logic                       w_out_fire;
  logic                       w_main_last;
  logic                       w_final;
  logic                       w_restart;
  logic [IDX_W-1:0]           w_idx_inc;
  logic                       w_run_nx;
  logic [CNT_W-1:0]           w_in_cnt_nx;
  logic                       w_accept_nx;
  logic                       w_main_valid_nx;
  logic [SIZE-1:0][WIDTH-1:0] w_main_data_nx;
  logic [IDX_W-1:0]           w_main_idx_nx;
  logic                       w_skid_valid_nx;
  logic [SIZE-1:0][WIDTH-1:0] w_skid_data_nx;
  logic [IDX_W-1:0]           w_skid_idx_nx;

  // Handshake events and the next-cycle view used to register data_in_ready
  always_comb begin
    w_in_fire   = bus.data_in_valid & r_in_ready;
    w_out_fire  = r_main_valid & bus.data_out_ready;
    w_main_last = (r_main_idx == LAST_IDX);
    w_final     = (r_state == S_RUN) & w_out_fire & (r_out_cnt == FINAL_C);
    w_restart   = (r_state == S_DONE) & restart;
    w_idx_inc   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    w_run_nx    = (r_state == S_RUN) ? !w_final : restart;
    w_in_cnt_nx = w_restart ? '0 : r_in_cnt + CNT_W'(w_in_fire);
    w_accept_nx = w_run_nx & (w_in_cnt_nx < TOTAL_C);
  end

  // Skid steering: main refills from skid first, otherwise from the input; skid only catches a stalled beat
  always_comb begin
    w_main_valid_nx = r_main_valid;
    w_main_data_nx  = r_main_data;
    w_main_idx_nx   = r_main_idx;
    w_skid_valid_nx = r_skid_valid;
    w_skid_data_nx  = r_skid_data;
    w_skid_idx_nx   = r_skid_idx;
    if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        // ready was low, so no input can arrive in this cycle
        w_main_valid_nx = 1'b1;
        w_main_data_nx  = r_skid_data;
        w_main_idx_nx   = r_skid_idx;
        w_skid_valid_nx = 1'b0;
      end else if (w_in_fire) begin
        w_main_valid_nx = 1'b1;
        w_main_data_nx  = bus.data_in;
        w_main_idx_nx   = r_idx;
      end else begin
        w_main_valid_nx = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_valid_nx = 1'b1;
      w_skid_data_nx  = bus.data_in;
      w_skid_idx_nx   = r_idx;
    end
  end

  // Payload registers carry no reset; their contents only matter when the matching valid is set
  always_ff @(posedge clk) begin
    r_main_data <= w_main_data_nx;
    r_skid_data <= w_skid_data_nx;
  end

  // Control FSM: counters, buffer valids, stored index tags and registered ready/done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_RUN;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_pass_count <= '0;
      r_idx        <= '0;
      r_in_ready   <= 1'b0;
      r_done       <= 1'b0;
      r_main_valid <= 1'b0;
      r_main_idx   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_idx   <= '0;
    end else begin
      r_main_valid <= w_main_valid_nx;
      r_main_idx   <= w_main_idx_nx;
      r_skid_valid <= w_skid_valid_nx;
      r_skid_idx   <= w_skid_idx_nx;
      r_in_cnt     <= w_in_cnt_nx;
      r_in_ready   <= w_accept_nx & !w_skid_valid_nx;
      case (r_state)
        S_RUN: begin
          if (w_in_fire) r_idx <= w_idx_inc;
          if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
          if (w_out_fire && w_main_last) r_pass_count <= r_pass_count + 1'b1;
          if (w_final) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (restart) begin
            r_state      <= S_RUN;
            r_done       <= 1'b0;
            r_out_cnt    <= '0;
            r_pass_count <= '0;
            r_idx        <= '0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign bus.data_in_ready  = r_in_ready;
  assign bus.data_out       = r_main_data;
  assign bus.data_out_valid = r_main_valid;
  assign bus.data_out_index = r_main_idx;
  assign bus.data_out_last  = r_main_valid & w_main_last;
  assign pass_count         = r_pass_count;
  assign done               = r_done;

endmodule
